// File: rtl/mem_map_pkg.sv
// mem_map_pkg: memory map defaults, bus widths and the bus sequencer's FSM
// state encoding. Shared by the bus interface unit and by any other master
// that needs the address decoder.
package mem_map_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    // ROM occupies 0..ROM_LAST. RAM occupies RAM_FIRST..RAM_LAST.
    localparam logic [ADDR_W-1:0] ROM_LAST_DEF  = 16'h0014;
    localparam logic [ADDR_W-1:0] RAM_FIRST_DEF = 16'h0015;
    localparam logic [ADDR_W-1:0] RAM_LAST_DEF  = 16'h001D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } biu_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational memory-map legality check.
//   addr  in  request address
//   write in  1 = write, 0 = read
//   legal out access is allowed by the map
// A read is legal anywhere from 0 up to RAM_LAST. A write is legal only
// inside RAM. ROM_LAST is not used by the check itself. Any gap between ROM
// and RAM is readable, which matches the map seen by the core.
module bus_addr_decode
    import mem_map_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_FIRST = RAM_FIRST_DEF,
    parameter logic [ADDR_W-1:0] RAM_LAST  = RAM_LAST_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic              legal
);

    always_comb begin
        if (write) legal = (addr >= RAM_FIRST) && (addr <= RAM_LAST);
        else       legal = (addr <= RAM_LAST);
    end

endmodule

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: single-outstanding request sequencer between the 6502
// core and the latched ROM/RAM block.
//   CLK, RST           clock; asynchronous active-high reset
//   REQ_*              core request channel (valid/ready)
//   RSP_*              response pulse, read data and map-error flag
//   ERR_COUNT          saturating count of rejected requests
//   ADRESSE_CPU, READ_ENABLE, WRITE_ENABLE, DATA_to_MEMORY_IN
//                      registered memory bus (the memory samples it on CLK rise)
//   DATA_MICRO_OUT     memory read data, valid from the falling edge after sampling
// Every request takes two cycles from accept to response: the ISSUE cycle
// drives the strobes and the WAIT cycle captures the data. A new request can
// be accepted in WAIT, so the unit can take one request every 2 cycles.
module bus_interface_unit
    import mem_map_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_LAST  = ROM_LAST_DEF,
    parameter logic [ADDR_W-1:0] RAM_FIRST = RAM_FIRST_DEF,
    parameter logic [ADDR_W-1:0] RAM_LAST  = RAM_LAST_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              REQ_WRITE,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic [7:0]        ERR_COUNT,
    output logic [ADDR_W-1:0] ADRESSE_CPU,
    output logic              READ_ENABLE,
    output logic              WRITE_ENABLE,
    output logic [DATA_W-1:0] DATA_to_MEMORY_IN,
    input  logic [DATA_W-1:0] DATA_MICRO_OUT
);

    // ROM_LAST documents the map. Only the RAM bounds gate legality, because
    // every read at or below RAM_LAST is accepted.
    localparam logic [ADDR_W-1:0] ROM_TOP = ROM_LAST;

    biu_state_t        state_q, state_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              legal_q, legal_d;   // decode result of the in-flight request
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic dec_legal;
    logic accept;

    bus_addr_decode #(
        .RAM_FIRST (RAM_FIRST),
        .RAM_LAST  (RAM_LAST)
    ) u_decode (
        .addr  (REQ_ADDR),
        .write (REQ_WRITE),
        .legal (dec_legal)
    );

    // ready_q is low only in ISSUE, so an accept can only happen in IDLE or WAIT.
    assign accept = REQ_VALID && ready_q;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = accept ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ready_d     = (state_d != ST_ISSUE);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        legal_d     = legal_q;
        write_d     = write_q;
        re_d        = 1'b0;   // strobes last exactly the ISSUE cycle
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;

        // The response is built from legal_q/write_q before a back-to-back
        // accept in the same cycle overwrites them.
        if (state_q == ST_WAIT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (legal_q && !write_q) ? DATA_MICRO_OUT : '0;
            rsp_err_d   = !legal_q;
        end

        if (accept) begin
            addr_d  = REQ_ADDR;
            legal_d = dec_legal;
            write_d = REQ_WRITE;
            if (dec_legal) begin
                wdata_d = REQ_WDATA;
                re_d    = !REQ_WRITE;
                we_d    = REQ_WRITE;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            legal_q     <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            ready_q     <= ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            re_q        <= re_d;
            we_q        <= we_d;
            legal_q     <= legal_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign REQ_READY         = ready_q;
    assign RSP_VALID         = rsp_valid_q;
    assign RSP_DATA          = rsp_data_q;
    assign RSP_ERR           = rsp_err_q;
    assign ERR_COUNT         = err_cnt_q;
    assign ADRESSE_CPU       = addr_q;
    assign READ_ENABLE       = re_q;
    assign WRITE_ENABLE      = we_q;
    assign DATA_to_MEMORY_IN = wdata_q;

    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;

endmodule
